tm_stats_ctrl: RTL and testbench
================================

# tm_stats_ctrl

Per-thread transactional-memory statistics controller that sits directly upstream of the TM ALU (`tm_alu`) and consumes its results. It counts retired instructions inside each thread's open transaction. On commit it issues {AvgTxLen, InstExed, CurTxLen} to the ALU and writes {AvgTxLen_new, InstExed_new} back into the per-thread stats table after the ALU's fixed latency. Same-thread commits are stalled while an update is in flight.

## Interface
- NTHREADS, 4: number of hardware threads (power of two, ≥2).
- TIDW, 2: thread-id width, log2(NTHREADS).
- ALU_LAT, 4: cycles from ALU inputs valid to ALU outputs valid (4 for `tm_alu`).

- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- tx_valid  in  1  event present this cycle.
- tx_op  in  2  00 retire, 01 begin, 10 commit, 11 abort.
- tx_tid  in  TIDW  thread of the event.
- tx_ready  out  1  event accepted when tx_valid & tx_ready.
- alu_avg  out  8  to ALU AvgTxLen (registered).
- alu_inst  out  8  to ALU InstExed (registered).
- alu_cur  out  8  to ALU CurTxLen (registered).
- alu_avg_new  in  8  from ALU AvgTxLen_new.
- alu_inst_new  in  8  from ALU InstExed_new.
- rd_tid  in  TIDW  stats read select.
- rd_avg  out  8  table AvgTxLen[rd_tid], combinational read.
- rd_inst  out  8  table InstExed[rd_tid], combinational read.
- upd_valid  out  1  one-cycle pulse in the writeback cycle.
- upd_tid  out  TIDW  thread written when upd_valid.

## Operation
- Per thread: active bit, cur counter (8b), pend bit, table entries avg (8b) and inst (8b).
- tx_ready = !(tx_valid & tx_op==10 & pend[tx_tid]). Other ops are always accepted.
- Retire: if active, cur += 1. If not active, ignored.
- Begin: active=1, cur=0. Begin while already active restarts the transaction. Begin is allowed while pend=1.
- Abort: active=0, cur=0. No table update.
- Commit while not active: accepted, no effect.
- Commit while active:
  - active=0, cur=0.
  - If inst[tid]==255: no issue. The table freezes, because ALU InstExed+1 would wrap.
  - Otherwise: register alu_avg=avg[tid], alu_inst=inst[tid], alu_cur=cur[tid]. Set pend[tid]=1. Push {valid, tid} into an ALU_LAT+1 deep shift pipe.
- When no issue occurs, alu_* hold their previous values. The ALU computes on them, but the results are discarded because no pipe entry is valid.
- Writeback happens when the pipe tail is valid:
  - avg[tid]=alu_avg_new, inst[tid]=alu_inst_new.
  - pend[tid]=0.
  - upd_valid=1, upd_tid=tid.
- One event per cycle, so at most one issue and one writeback per cycle. Writeback and an issue to a different thread may coincide; both proceed.

## Timing
- Commit accepted in cycle c.
- alu_* valid in cycle c+1.
- ALU outputs valid in cycle c+1+ALU_LAT (c+5).
- Table write and upd_valid occur in cycle c+5, committed at the end of c+5.
- pend[tid]=1 for cycles c+1..c+5, so a same-thread commit in any of those cycles sees tx_ready=0. In c+6 it is accepted and reads the updated entry.
- A retire or begin in cycle c for the committing thread applies after the commit, i.e. to the next transaction.
- Reset values: tx_ready=1 (pend clear), alu_* =0, rd_* =0, upd_valid=0, upd_tid=0. All table entries, counters, active, pend and pipe valids are 0.
- Reset mid-flight clears the pipe valids. In-flight ALU results are never written, and the ALU is reset by the same signal.

## Configuration
- TM_CNT_SAT_EN defined: cur saturates at 255. Retires beyond that are dropped.
- TM_CNT_SAT_EN undefined: cur wraps modulo 256 (255+1 → 0).

## Test plan
- First transaction:
  - Stimulus: reset; thread 0: begin, 5 retires, commit in cycle c.
  - Required response: alu_avg=0, alu_inst=0, alu_cur=5 in c+1. upd_valid with upd_tid=0 in c+5. Then rd_tid=0 gives avg=5, inst=1.
- Second transaction:
  - Stimulus: continuing from the first test, thread 0 commits a 9-instruction transaction.
  - Required response: ALU issue {5,1,9}; writeback avg=7, inst=2.
- Same-thread stall:
  - Stimulus: thread 1 commit in c, then begin and commit again in c+2.
  - Required response: tx_ready=0 for the commit in c+2..c+5. Accepted in c+6 with alu_inst=1.
- Abort and interleaving:
  - Stimulus: thread 2 begin, 3 retires, abort, then commit.
  - Required response: no issue, table unchanged. Thread 3's commit in the same window issues normally.
- Saturation:
  - Stimulus: 300 retires, then commit.
  - Required response: alu_cur=255 with TM_CNT_SAT_EN; alu_cur=44 without.
- Reset and frozen entry:
  - Stimulus: reset asserted in c+3 of an in-flight commit.
  - Required response: no upd_valid, all rd_* =0.
  - Also: a thread with inst=255 commits → no issue, no upd_valid.

Source files
------------

// File: rtl/tm_stats_ctrl.sv
// Per-thread transactional-memory statistics controller feeding a fixed-latency TM ALU.
// Optional macro TM_CNT_SAT_EN: saturate the per-thread instruction counter at 255 instead of wrapping.
module tm_stats_ctrl #(
    parameter int NTHREADS = 4,
    parameter int TIDW     = 2,
    parameter int ALU_LAT  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_valid,
    input  logic [1:0]      tx_op,
    input  logic [TIDW-1:0] tx_tid,
    output logic            tx_ready,
    output logic [7:0]      alu_avg,
    output logic [7:0]      alu_inst,
    output logic [7:0]      alu_cur,
    input  logic [7:0]      alu_avg_new,
    input  logic [7:0]      alu_inst_new,
    input  logic [TIDW-1:0] rd_tid,
    output logic [7:0]      rd_avg,
    output logic [7:0]      rd_inst,
    output logic            upd_valid,
    output logic [TIDW-1:0] upd_tid
);

    localparam logic [1:0] OP_RETIRE = 2'b00;
    localparam logic [1:0] OP_BEGIN  = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;

    logic [NTHREADS-1:0] active_vec;
    logic [NTHREADS-1:0] pend_vec;
    logic [7:0]          avg_arr  [NTHREADS];
    logic [7:0]          inst_arr [NTHREADS];
    logic [7:0]          cur_arr  [NTHREADS];

    logic                accept;
    logic                issue;
    logic                wb_valid;
    logic [TIDW-1:0]     wb_tid;

    logic [ALU_LAT:0]    pipe_valid_reg;
    logic [TIDW-1:0]     pipe_tid_reg [ALU_LAT+1];

    // Only a commit to a thread with an update in flight is held off.
    assign tx_ready = !(tx_valid && (tx_op == OP_COMMIT) && pend_vec[tx_tid]);
    assign accept   = tx_valid && tx_ready;

    // A full InstExed entry freezes the table because the ALU increment would wrap.
    assign issue = accept && (tx_op == OP_COMMIT) && active_vec[tx_tid]
                   && (inst_arr[tx_tid] != 8'hFF);

    assign wb_valid  = pipe_valid_reg[ALU_LAT];
    assign wb_tid    = pipe_tid_reg[ALU_LAT];
    assign upd_valid = wb_valid;
    assign upd_tid   = wb_tid;

    assign rd_avg  = avg_arr[rd_tid];
    assign rd_inst = inst_arr[rd_tid];

    generate
        for (genvar gi = 0; gi < NTHREADS; gi++) begin : g_thread
            logic       active_reg;
            logic       pend_reg;
            logic [7:0] cur_reg;
            logic [7:0] cur_inc;
            logic [7:0] avg_reg;
            logic [7:0] inst_reg;
            logic       hit;
            logic       wb_hit;

            assign hit    = accept && (tx_tid == TIDW'(gi));
            assign wb_hit = wb_valid && (wb_tid == TIDW'(gi));

`ifdef TM_CNT_SAT_EN
            assign cur_inc = (cur_reg == 8'hFF) ? cur_reg : cur_reg + 8'd1;
`else
            assign cur_inc = cur_reg + 8'd1;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    active_reg <= 1'b0;
                    pend_reg   <= 1'b0;
                    cur_reg    <= 8'd0;
                    avg_reg    <= 8'd0;
                    inst_reg   <= 8'd0;
                end else begin
                    if (hit) begin
                        case (tx_op)
                            OP_RETIRE: begin
                                if (active_reg) begin
                                    cur_reg <= cur_inc;
                                end
                            end
                            OP_BEGIN: begin
                                active_reg <= 1'b1;
                                cur_reg    <= 8'd0;
                            end
                            default: begin
                                active_reg <= 1'b0;
                                cur_reg    <= 8'd0;
                            end
                        endcase
                    end
                    if (issue && hit) begin
                        pend_reg <= 1'b1;
                    end else if (wb_hit) begin
                        pend_reg <= 1'b0;
                    end
                    if (wb_hit) begin
                        avg_reg  <= alu_avg_new;
                        inst_reg <= alu_inst_new;
                    end
                end
            end

            assign active_vec[gi] = active_reg;
            assign pend_vec[gi]   = pend_reg;
            assign cur_arr[gi]    = cur_reg;
            assign avg_arr[gi]    = avg_reg;
            assign inst_arr[gi]   = inst_reg;
        end
    endgenerate

    // ALU operands hold their last issued values when nothing is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_avg  <= 8'd0;
            alu_inst <= 8'd0;
            alu_cur  <= 8'd0;
        end else if (issue) begin
            alu_avg  <= avg_arr[tx_tid];
            alu_inst <= inst_arr[tx_tid];
            alu_cur  <= cur_arr[tx_tid];
        end
    end

    // Tracks which thread owns each result flowing through the ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_reg <= '0;
            for (int i = 0; i <= ALU_LAT; i++) begin
                pipe_tid_reg[i] <= '0;
            end
        end else begin
            pipe_valid_reg  <= {pipe_valid_reg[ALU_LAT-1:0], issue};
            pipe_tid_reg[0] <= issue ? tx_tid : '0;
            for (int i = 1; i <= ALU_LAT; i++) begin
                pipe_tid_reg[i] <= pipe_tid_reg[i-1];
            end
        end
    end

endmodule

// File: tb/tb_tm_stats_ctrl.sv
// Directed self-checking bench for tm_stats_ctrl with a behavioural 4-cycle TM ALU model.
module tb_tm_stats_ctrl;

    localparam logic [1:0] OP_RETIRE = 2'b00;
    localparam logic [1:0] OP_BEGIN  = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [1:0] tx_op;
    logic [1:0] tx_tid;
    logic       tx_ready;
    logic [7:0] alu_avg, alu_inst, alu_cur;
    logic [7:0] alu_avg_new, alu_inst_new;
    logic [1:0] rd_tid;
    logic [7:0] rd_avg, rd_inst;
    logic       upd_valid;
    logic [1:0] upd_tid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_c = 0;
    int upd_cnt = 0;
    int last_upd_cyc = -1;
    logic [1:0] last_upd_tid = 2'd0;

    always #5 clk = ~clk;

    tm_stats_ctrl #(.NTHREADS(4), .TIDW(2), .ALU_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_op(tx_op), .tx_tid(tx_tid), .tx_ready(tx_ready),
        .alu_avg(alu_avg), .alu_inst(alu_inst), .alu_cur(alu_cur),
        .alu_avg_new(alu_avg_new), .alu_inst_new(alu_inst_new),
        .rd_tid(rd_tid), .rd_avg(rd_avg), .rd_inst(rd_inst),
        .upd_valid(upd_valid), .upd_tid(upd_tid)
    );

    // TM ALU model: running average and instruction count, outputs 4 cycles after inputs.
    logic [7:0] s_avg [4];
    logic [7:0] s_inst [4];

    function automatic logic [7:0] alu_average(input logic [7:0] a, input logic [7:0] n,
                                               input logic [7:0] c);
        logic [15:0] s;
        s = 16'(a) * 16'(n) + 16'(c);
        return 8'(s / (16'(n) + 16'd1));
    endfunction

    always @(posedge clk) begin
        s_avg[0]  <= alu_average(alu_avg, alu_inst, alu_cur);
        s_inst[0] <= alu_inst + 8'd1;
        for (int i = 1; i < 4; i++) begin
            s_avg[i]  <= s_avg[i-1];
            s_inst[i] <= s_inst[i-1];
        end
    end
    assign alu_avg_new  = s_avg[3];
    assign alu_inst_new = s_inst[3];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (upd_valid === 1'b1) begin
            upd_cnt      = upd_cnt + 1;
            last_upd_cyc = cyc;
            last_upd_tid = upd_tid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] tid);
        int n;
        n = 0;
        tx_valid = 1'b1;
        tx_op    = op;
        tx_tid   = tid;
        #1;
        while (tx_ready !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: op=%0d tid=%0d tx_ready=%b required 1", op, tid, tx_ready);
        end
        last_c = cyc;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready);
        end
        checks++;
        if ({alu_avg, alu_inst, alu_cur} !== 24'd0) begin
            errors++; $display("FAIL reset_alu: got %0d/%0d/%0d required 0/0/0", alu_avg, alu_inst, alu_cur);
        end
        checks++;
        if (upd_valid !== 1'b0 || upd_tid !== 2'd0) begin
            errors++; $display("FAIL reset_upd: got valid=%b tid=%0d required 0/0", upd_valid, upd_tid);
        end
        for (int t = 0; t < 4; t++) begin
            rd_tid = 2'(t);
            #1;
            checks++;
            if (rd_avg !== 8'd0 || rd_inst !== 8'd0) begin
                errors++; $display("FAIL reset_rd%0d: got %0d/%0d required 0/0", t, rd_avg, rd_inst);
            end
        end
    endtask

    task automatic test_first_tx();
        int c;
        int u0;
        u0 = upd_cnt;
        send(OP_BEGIN, 2'd0);
        repeat (5) send(OP_RETIRE, 2'd0);
        send(OP_COMMIT, 2'd0);
        c = last_c;
        checks++;
        if (alu_avg !== 8'd0 || alu_inst !== 8'd0 || alu_cur !== 8'd5) begin
            errors++; $display("FAIL first_issue: got %0d/%0d/%0d required 0/0/5", alu_avg, alu_inst, alu_cur);
        end
        repeat (4) tick();
        checks++;
        if (upd_valid !== 1'b1 || upd_tid !== 2'd0) begin
            errors++; $display("FAIL first_upd_pulse: got valid=%b tid=%0d required 1/0", upd_valid, upd_tid);
        end
        tick();
        checks++;
        if (upd_cnt - u0 !== 1 || last_upd_cyc !== c + 5) begin
            errors++; $display("FAIL first_upd_timing: got count=%0d cycle=%0d required 1/%0d", upd_cnt - u0, last_upd_cyc, c + 5);
        end
        rd_tid = 2'd0;
        #1;
        checks++;
        if (rd_avg !== 8'd5 || rd_inst !== 8'd1) begin
            errors++; $display("FAIL first_table: got %0d/%0d required 5/1", rd_avg, rd_inst);
        end
    endtask

    task automatic test_second_tx();
        send(OP_BEGIN, 2'd0);
        repeat (9) send(OP_RETIRE, 2'd0);
        send(OP_COMMIT, 2'd0);
        checks++;
        if (alu_avg !== 8'd5 || alu_inst !== 8'd1 || alu_cur !== 8'd9) begin
            errors++; $display("FAIL second_issue: got %0d/%0d/%0d required 5/1/9", alu_avg, alu_inst, alu_cur);
        end
        repeat (5) tick();
        rd_tid = 2'd0;
        #1;
        checks++;
        if (rd_avg !== 8'd7 || rd_inst !== 8'd2) begin
            errors++; $display("FAIL second_table: got %0d/%0d required 7/2", rd_avg, rd_inst);
        end
    endtask

    task automatic test_back_to_back();
        send(OP_BEGIN, 2'd1);
        send(OP_COMMIT, 2'd1);
        tx_valid = 1'b1;
        tx_op    = OP_BEGIN;
        tx_tid   = 2'd1;
        tick();
        tx_op = OP_COMMIT;
        #1;
        for (int k = 2; k <= 5; k++) begin
            checks++;
            if (tx_ready !== 1'b0) begin
                errors++; $display("FAIL stall_ready_c%0d: got %b required 0", k, tx_ready);
            end
            if (k == 5) begin
                checks++;
                if (upd_valid !== 1'b1 || upd_tid !== 2'd1) begin
                    errors++; $display("FAIL stall_upd: got valid=%b tid=%0d required 1/1", upd_valid, upd_tid);
                end
            end
            tick();
            #1;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release: got %b required 1", tx_ready);
        end
        tick();
        tx_valid = 1'b0;
        checks++;
        if (alu_avg !== 8'd0 || alu_inst !== 8'd1 || alu_cur !== 8'd0) begin
            errors++; $display("FAIL stall_issue: got %0d/%0d/%0d required 0/1/0", alu_avg, alu_inst, alu_cur);
        end
        repeat (5) tick();
        rd_tid = 2'd1;
        #1;
        checks++;
        if (rd_avg !== 8'd0 || rd_inst !== 8'd2) begin
            errors++; $display("FAIL stall_table: got %0d/%0d required 0/2", rd_avg, rd_inst);
        end
    endtask

    task automatic test_abort_interleave();
        int c3;
        int u0;
        u0 = upd_cnt;
        send(OP_BEGIN, 2'd3);
        repeat (2) send(OP_RETIRE, 2'd3);
        send(OP_BEGIN, 2'd2);
        repeat (3) send(OP_RETIRE, 2'd2);
        send(OP_COMMIT, 2'd3);
        c3 = last_c;
        send(OP_ABORT, 2'd2);
        send(OP_COMMIT, 2'd2);
        checks++;
        if (alu_avg !== 8'd0 || alu_inst !== 8'd0 || alu_cur !== 8'd2) begin
            errors++; $display("FAIL abort_alu_hold: got %0d/%0d/%0d required 0/0/2", alu_avg, alu_inst, alu_cur);
        end
        repeat (6) tick();
        checks++;
        if (upd_cnt - u0 !== 1 || last_upd_tid !== 2'd3 || last_upd_cyc !== c3 + 5) begin
            errors++; $display("FAIL abort_upd: got count=%0d tid=%0d cycle=%0d required 1/3/%0d",
                               upd_cnt - u0, last_upd_tid, last_upd_cyc, c3 + 5);
        end
        rd_tid = 2'd2;
        #1;
        checks++;
        if (rd_avg !== 8'd0 || rd_inst !== 8'd0) begin
            errors++; $display("FAIL abort_table2: got %0d/%0d required 0/0", rd_avg, rd_inst);
        end
        rd_tid = 2'd3;
        #1;
        checks++;
        if (rd_avg !== 8'd2 || rd_inst !== 8'd1) begin
            errors++; $display("FAIL abort_table3: got %0d/%0d required 2/1", rd_avg, rd_inst);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_cur;
        logic [7:0] exp_avg;
`ifdef TM_CNT_SAT_EN
        exp_cur = 8'd255;
        exp_avg = 8'd89;
`else
        exp_cur = 8'd44;
        exp_avg = 8'd19;
`endif
        send(OP_BEGIN, 2'd0);
        repeat (300) send(OP_RETIRE, 2'd0);
        send(OP_COMMIT, 2'd0);
        checks++;
        if (alu_avg !== 8'd7 || alu_inst !== 8'd2 || alu_cur !== exp_cur) begin
            errors++; $display("FAIL sat_issue: got %0d/%0d/%0d required 7/2/%0d", alu_avg, alu_inst, alu_cur, exp_cur);
        end
        repeat (5) tick();
        rd_tid = 2'd0;
        #1;
        checks++;
        if (rd_avg !== exp_avg || rd_inst !== 8'd3) begin
            errors++; $display("FAIL sat_table: got %0d/%0d required %0d/3", rd_avg, rd_inst, exp_avg);
        end
    endtask

    task automatic test_reset_midflight();
        int u0;
        u0 = upd_cnt;
        send(OP_BEGIN, 2'd1);
        repeat (4) send(OP_RETIRE, 2'd1);
        send(OP_COMMIT, 2'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        checks++;
        if (upd_cnt !== u0) begin
            errors++; $display("FAIL midreset_upd: got %0d writebacks required 0", upd_cnt - u0);
        end
        checks++;
        if ({alu_avg, alu_inst, alu_cur} !== 24'd0 || tx_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_state: got alu=%0d/%0d/%0d ready=%b required 0/0/0 1",
                               alu_avg, alu_inst, alu_cur, tx_ready);
        end
        for (int t = 0; t < 4; t++) begin
            rd_tid = 2'(t);
            #1;
            checks++;
            if (rd_avg !== 8'd0 || rd_inst !== 8'd0) begin
                errors++; $display("FAIL midreset_rd%0d: got %0d/%0d required 0/0", t, rd_avg, rd_inst);
            end
        end
    endtask

    task automatic test_frozen();
        int u0;
        for (int i = 0; i < 255; i++) begin
            send(OP_BEGIN, 2'd3);
            send(OP_COMMIT, 2'd3);
            repeat (5) tick();
        end
        rd_tid = 2'd3;
        #1;
        checks++;
        if (rd_avg !== 8'd0 || rd_inst !== 8'd255) begin
            errors++; $display("FAIL frozen_fill: got %0d/%0d required 0/255", rd_avg, rd_inst);
        end
        u0 = upd_cnt;
        send(OP_BEGIN, 2'd3);
        repeat (3) send(OP_RETIRE, 2'd3);
        send(OP_COMMIT, 2'd3);
        checks++;
        if (alu_avg !== 8'd0 || alu_inst !== 8'd254 || alu_cur !== 8'd0) begin
            errors++; $display("FAIL frozen_alu_hold: got %0d/%0d/%0d required 0/254/0", alu_avg, alu_inst, alu_cur);
        end
        repeat (8) tick();
        checks++;
        if (upd_cnt !== u0) begin
            errors++; $display("FAIL frozen_upd: got %0d writebacks required 0", upd_cnt - u0);
        end
        rd_tid = 2'd3;
        #1;
        checks++;
        if (rd_avg !== 8'd0 || rd_inst !== 8'd255) begin
            errors++; $display("FAIL frozen_table: got %0d/%0d required 0/255", rd_avg, rd_inst);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_op    = OP_RETIRE;
        tx_tid   = 2'd0;
        rd_tid   = 2'd0;
        test_reset();
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
        test_first_tx();
        $display("test_first_tx done: checks=%0d errors=%0d", checks, errors);
        test_second_tx();
        $display("test_second_tx done: checks=%0d errors=%0d", checks, errors);
        test_back_to_back();
        $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
        test_abort_interleave();
        $display("test_abort_interleave done: checks=%0d errors=%0d", checks, errors);
        test_saturation();
        $display("test_saturation done: checks=%0d errors=%0d", checks, errors);
        test_reset_midflight();
        $display("test_reset_midflight done: checks=%0d errors=%0d", checks, errors);
        test_frozen();
        $display("test_frozen done: checks=%0d errors=%0d", checks, errors);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
